// File: rtl/data_mem_responder.sv
// Data-memory responder: 128x32 little-endian RAM with RV32I byte/half/word
// access, alignment/funct3 checking and a self-clearing pass after every reset.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int DEPTH_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic              err_sticky
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  clr_idx, clr_nx;
  logic [DATA_W-1:0] mem [DEPTH_W];

  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;
  logic              size_ok, load_only, misaligned, st_ok, ld_ok;
  logic [3:0]        st_mask;
  logic [DATA_W-1:0] st_data;

  logic [IDX_W-1:0]  we_idx;
  logic [3:0]        we_mask;
  logic [DATA_W-1:0] we_data;
  logic              load_take, err_nx;
  logic [DATA_W-1:0] load_val;

  assign word_idx = addr[ADDR_W-1:2];
  assign lane     = addr[1:0];
  assign rd_word  = mem[word_idx];
  assign busy     = (state == CLEAR);

  // Request decode: legality, alignment, lane mask and load extraction.
  always_comb begin
    size_ok    = 1'b0;
    load_only  = 1'b0;
    misaligned = 1'b0;
    st_mask    = '0;
    st_data    = wr_data;
    ld_val     = '0;
    unique case (lane)
      2'd0: ld_byte = rd_word[7:0];
      2'd1: ld_byte = rd_word[15:8];
      2'd2: ld_byte = rd_word[23:16];
      2'd3: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      3'b000: begin
        size_ok = 1'b1;
        st_mask = 4'b0001 << lane;
        st_data = {4{wr_data[7:0]}};
        ld_val  = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      end
      3'b001: begin
        size_ok    = 1'b1;
        misaligned = addr[0];
        st_mask    = addr[1] ? 4'b1100 : 4'b0011;
        st_data    = {2{wr_data[15:0]}};
        ld_val     = {{(DATA_W-16){ld_half[15]}}, ld_half};
      end
      3'b010: begin
        size_ok    = 1'b1;
        misaligned = (lane != 2'b00);
        st_mask    = 4'b1111;
        ld_val     = rd_word;
      end
      3'b100: begin
        size_ok   = 1'b1;
        load_only = 1'b1;
        ld_val    = {{(DATA_W-8){1'b0}}, ld_byte};
      end
      3'b101: begin
        size_ok    = 1'b1;
        load_only  = 1'b1;
        misaligned = addr[0];
        ld_val     = {{(DATA_W-16){1'b0}}, ld_half};
      end
      default: size_ok = 1'b0;
    endcase
    ld_ok = size_ok && !misaligned;
    st_ok = ld_ok && !load_only;
  end

  // Next state plus array write port and registered-output next values.
  always_comb begin
    state_nx  = state;
    clr_nx    = clr_idx;
    we_idx    = word_idx;
    we_mask   = '0;
    we_data   = '0;
    load_take = 1'b0;
    load_val  = '0;
    err_nx    = 1'b0;
    unique case (state)
      CLEAR: begin
        we_idx  = clr_idx;
        we_mask = '1;
        clr_nx  = clr_idx + 1'b1;
        if (clr_idx == '1) state_nx = READY;
      end
      READY: begin
        if (wr) begin
          if (st_ok) begin
            we_mask = st_mask;
            we_data = st_data;
          end
          err_nx = !st_ok || rd;
        end else if (rd) begin
          load_take = 1'b1;
          load_val  = ld_ok ? ld_val : '0;
          err_nx    = !ld_ok;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we_mask[b]) mem[we_idx][8*b +: 8] <= we_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state    <= state_nx;
      clr_idx  <= clr_nx;
      rd_valid <= load_take;
      err      <= err_nx;
      if (load_take) rd_data <= load_val;
      if (err_nx) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: byte-array reference model checked
// every cycle, plus literal expectations on selected transactions.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr, rd;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  funct3;
  logic [31:0] rd_data;
  logic        rd_valid, busy, err, err_sticky;

  int vectors = 0;
  int miscompares = 0;

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH_W(128)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .err(err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte array, clear countdown, registered outputs.
  logic [7:0]  mb [512];
  int          clear_left = 128;
  logic [31:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0, m_err = 1'b0, m_sticky = 1'b0;

  task automatic model_step(input logic s_rst, input logic s_wr, input logic s_rd,
                            input int a, input logic [31:0] d, input logic [2:0] f3);
    int n;
    logic sgn, lonly, st_ok, ld_ok;
    logic [31:0] v;
    if (s_rst) begin
      clear_left = 128;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_err      = 1'b0;
      m_sticky   = 1'b0;
      for (int i = 0; i < 512; i++) mb[i] = 8'h00;
      return;
    end
    m_rd_valid = 1'b0;
    m_err      = 1'b0;
    if (clear_left > 0) begin
      clear_left--;
      return;
    end
    sgn = 1'b0; lonly = 1'b0; n = 0;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: begin n = 1; lonly = 1'b1; end
      3'd5: begin n = 2; lonly = 1'b1; end
      default: n = 0;
    endcase
    ld_ok = (n != 0) && (a % n == 0);
    st_ok = ld_ok && !lonly;
    if (s_wr) begin
      if (st_ok) for (int i = 0; i < n; i++) mb[a + i] = d[8*i +: 8];
      m_err = !st_ok || s_rd;
    end else if (s_rd) begin
      m_rd_valid = 1'b1;
      m_err      = !ld_ok;
      v = '0;
      if (ld_ok) begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a + i];
        if (sgn && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      end
      m_rd_data = v;
    end
    if (m_err) m_sticky = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(reset, wr, rd, int'(addr), wr_data, funct3);
      #1;
      check("busy",       {31'b0, busy},       {31'b0, clear_left > 0});
      check("rd_valid",   {31'b0, rd_valid},   {31'b0, m_rd_valid});
      check("err",        {31'b0, err},        {31'b0, m_err});
      check("err_sticky", {31'b0, err_sticky}, {31'b0, m_sticky});
      check("rd_data",    rd_data,             m_rd_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Driver tasks start and end 2 time units after a rising edge.
  task automatic idle();
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; funct3 = 3'b010;
  endtask

  task automatic do_store(input logic [8:0] a, input logic [2:0] f3,
                          input logic [31:0] d, input logic exp_err);
    wr = 1'b1; rd = 1'b0; addr = a; funct3 = f3; wr_data = d;
    @(posedge clk); #2;
    idle();
    check("st_err", {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic do_load(input logic [8:0] a, input logic [2:0] f3,
                         input logic [31:0] exp, input logic exp_err);
    wr = 1'b0; rd = 1'b1; addr = a; funct3 = f3;
    @(posedge clk); #2;
    idle();
    check("ld_data",  rd_data, exp);
    check("ld_valid", {31'b0, rd_valid}, 32'd1);
    check("ld_err",   {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic wait_clear(input logic poke);
    int n = 0;
    if (poke) begin
      wr = 1'b1; rd = 1'b1; addr = 9'h1FC; funct3 = 3'b010; wr_data = 32'hDEADBEEF;
    end
    do begin
      @(posedge clk); #2;
      n++;
    end while (busy && n < 300);
    idle();
    check("busy_len", n, 128);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk); #2;
    check("rst_busy",   {31'b0, busy}, 32'd1);
    check("rst_rddata", rd_data, 32'h0);
    check("rst_err",    {30'b0, err, err_sticky}, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    wait_clear(1'b0);

    // Dirty the array, then reset and confirm the clear pass wipes it.
    do_store(9'h000, 3'b010, 32'h01234567, 1'b0);
    do_store(9'h1FC, 3'b010, 32'hCAFEF00D, 1'b0);
    do_load (9'h1FC, 3'b010, 32'hCAFEF00D, 1'b0);
    pulse_reset();
    wait_clear(1'b1);
    check("no_err_busy", {31'b0, err_sticky}, 32'd0);
    for (int i = 0; i < 128; i++) do_load(9'(i * 4), 3'b010, 32'h0, 1'b0);

    // Byte and sign handling.
    do_store(9'h010, 3'b010, 32'h80FF7F01, 1'b0);
    do_load (9'h013, 3'b000, 32'hFFFFFF80, 1'b0);
    do_load (9'h013, 3'b100, 32'h00000080, 1'b0);
    do_load (9'h012, 3'b001, 32'hFFFF80FF, 1'b0);
    do_load (9'h010, 3'b101, 32'h00007F01, 1'b0);
    do_load (9'h011, 3'b000, 32'h0000007F, 1'b0);

    // Partial stores.
    do_store(9'h020, 3'b010, 32'h11223344, 1'b0);
    do_store(9'h021, 3'b000, 32'h000000AA, 1'b0);
    do_store(9'h022, 3'b001, 32'h0000BEEF, 1'b0);
    do_load (9'h020, 3'b010, 32'hBEEFAA44, 1'b0);

    // Back-to-back loads.
    rd = 1'b1; addr = 9'h010; funct3 = 3'b010;
    @(posedge clk); #2;
    addr = 9'h020;
    check("b2b_first", rd_data, 32'h80FF7F01);
    @(posedge clk); #2;
    idle();
    check("b2b_second", rd_data, 32'hBEEFAA44);
    check("b2b_valid",  {31'b0, rd_valid}, 32'd1);

    // Misalignment and illegal encodings.
    do_store(9'h031, 3'b010, 32'h12345678, 1'b1);
    check("sticky_set", {31'b0, err_sticky}, 32'd1);
    do_load (9'h030, 3'b010, 32'h0, 1'b0);
    do_load (9'h033, 3'b001, 32'h0, 1'b1);
    do_store(9'h034, 3'b100, 32'h000000FF, 1'b1);
    do_load (9'h034, 3'b000, 32'h0, 1'b0);
    do_load (9'h020, 3'b011, 32'h0, 1'b1);
    do_load (9'h022, 3'b101, 32'h0000BEEF, 1'b0);
    check("sticky_hold", {31'b0, err_sticky}, 32'd1);

    // Store and load in the same cycle.
    wr = 1'b1; rd = 1'b1; addr = 9'h040; funct3 = 3'b010; wr_data = 32'h5;
    @(posedge clk); #2;
    idle();
    check("conf_valid", {31'b0, rd_valid}, 32'd0);
    check("conf_err",   {31'b0, err}, 32'd1);
    do_load(9'h040, 3'b010, 32'h5, 1'b0);

    // Reset during the clear pass.
    do_store(9'h1FC, 3'b010, 32'hCAFEF00D, 1'b0);
    pulse_reset();
    check("sticky_rst", {31'b0, err_sticky}, 32'd0);
    repeat (60) @(posedge clk);
    #2;
    check("mid_busy", {31'b0, busy}, 32'd1);
    pulse_reset();
    wait_clear(1'b0);
    do_load(9'h1FC, 3'b010, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
